// File: rtl/apb_txn_scheduler.sv
// Shares one APB master port between AXI read and write bursts: round-robin
// arbitration, then expansion of each burst into len+1 APB transfers.
module apb_txn_scheduler #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int INFO_WIDTH = ID_WIDTH + ADDR_WIDTH + 8 + 2 + 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [INFO_WIDTH-1:0]   rd_req_info,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [INFO_WIDTH-1:0]   wr_req_info,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rdata_id,
    output logic [1:0]              rdata_resp,
    output logic                    rdata_last,
    output logic                    bresp_valid,
    input  logic                    bresp_ready,
    output logic [ID_WIDTH-1:0]     bresp_id,
    output logic [1:0]              bresp_resp,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [DATA_WIDTH-1:0]   prdata
);

    // state  | meaning
    // IDLE   | waiting for a burst request, arbitration active
    // WDATA  | waiting for the next write beat
    // SETUP  | APB setup phase (psel=1, penable=0)
    // ACCESS | APB access phase, waiting for pready
    // RD_OUT | presenting a read beat to the AXI side
    // B_OUT  | presenting the write response
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RD_OUT, B_OUT} state_t;

    state_t                  state;
    logic                    last_grant_wr;
    logic [7:0]              count;
    logic [1:0]              burst;
    logic [2:0]              size;
    logic                    err;

    logic                    grant_rd;
    logic                    grant_wr;
    logic [INFO_WIDTH-1:0]   sel_info;
    logic [ID_WIDTH-1:0]     sel_id;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [1:0]              sel_burst;
    logic [2:0]              sel_size;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // Read wins a tie unless it was granted last; last_grant starts as write.
    assign grant_rd = (state == IDLE) && rd_req_valid && (!wr_req_valid || last_grant_wr);
    assign grant_wr = (state == IDLE) && wr_req_valid && !grant_rd;

    assign rd_req_ready = grant_rd;
    assign wr_req_ready = grant_wr;
    assign wdata_ready  = (state == WDATA);

    assign sel_info = grant_rd ? rd_req_info : wr_req_info;
    assign {sel_id, sel_addr, sel_len, sel_burst, sel_size} = sel_info;

    // WRAP is treated as INCR; the address simply rolls over at the top.
    assign next_addr = (burst == 2'b00) ? paddr : paddr + (ADDR_WIDTH'(1) << size);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant_wr <= 1'b1;
            count         <= '0;
            burst         <= '0;
            size          <= '0;
            err           <= 1'b0;
            rdata_valid   <= 1'b0;
            rdata         <= '0;
            rdata_id      <= '0;
            rdata_resp    <= '0;
            rdata_last    <= 1'b0;
            bresp_valid   <= 1'b0;
            bresp_id      <= '0;
            bresp_resp    <= '0;
            psel          <= 1'b0;
            penable       <= 1'b0;
            pwrite        <= 1'b0;
            paddr         <= '0;
            pwdata        <= '0;
            pstrb         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd || grant_wr) begin
                        last_grant_wr <= grant_wr;
                        pwrite        <= grant_wr;
                        paddr         <= sel_addr;
                        count         <= sel_len;
                        burst         <= sel_burst;
                        size          <= sel_size;
                        err           <= 1'b0;
                        if (grant_rd) begin
                            rdata_id <= sel_id;
                            psel     <= 1'b1;
                            state    <= SETUP;
                        end else begin
                            bresp_id <= sel_id;
                            state    <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (wdata_valid) begin
                        pwdata <= wdata;
                        pstrb  <= wstrb;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (!pwrite) begin
                            rdata       <= prdata;
                            rdata_resp  <= pslverr ? 2'b10 : 2'b00;
                            rdata_last  <= (count == 8'd0);
                            rdata_valid <= 1'b1;
                            state       <= RD_OUT;
                        end else if (count == 8'd0) begin
                            err         <= err | pslverr;
                            bresp_resp  <= (err | pslverr) ? 2'b10 : 2'b00;
                            bresp_valid <= 1'b1;
                            state       <= B_OUT;
                        end else begin
                            err   <= err | pslverr;
                            count <= count - 8'd1;
                            paddr <= next_addr;
                            state <= WDATA;
                        end
                    end
                end
                RD_OUT: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        if (rdata_last) begin
                            state <= IDLE;
                        end else begin
                            count <= count - 8'd1;
                            paddr <= next_addr;
                            psel  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                end
                B_OUT: begin
                    if (bresp_ready) begin
                        bresp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_txn_scheduler.sv
// Directed bench for apb_txn_scheduler with a small APB responder that logs
// every completed transfer; expectations are hand-computed per scenario.
module tb_apb_txn_scheduler;

    localparam int IW = 46;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_valid = 1'b0, wr_req_valid = 1'b0;
    logic          rd_req_ready, wr_req_ready;
    logic [IW-1:0] rd_req_info = '0, wr_req_info = '0;
    logic          wdata_valid = 1'b0, wdata_ready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          rdata_valid, rdata_ready = 1'b0;
    logic [31:0]   rdata;
    logic          rdata_id;
    logic [1:0]    rdata_resp;
    logic          rdata_last;
    logic          bresp_valid, bresp_ready = 1'b0;
    logic          bresp_id;
    logic [1:0]    bresp_resp;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [3:0]    pstrb;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic [31:0]   prdata = '0;

    apb_txn_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_info(rd_req_info),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_info(wr_req_info),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_id(rdata_id), .rdata_resp(rdata_resp), .rdata_last(rdata_last),
        .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bresp_id(bresp_id),
        .bresp_resp(bresp_resp),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // APB responder: pready after wait_states extra access cycles,
    // prdata = A000_0000 | transfer index, pslverr from err_mask.
    int          wait_states = 0;
    logic [15:0] err_mask = '0;
    int          xfer = 0;
    int          wcnt = 0;
    logic [31:0] log_addr [16];
    logic        log_write[16];
    logic [31:0] log_wdata[16];
    logic [3:0]  log_strb [16];
    int          log_en   [16];
    int          log_setup[16];

    always @(posedge clk) begin
        #1;
        if (psel && !penable && xfer < 16) log_setup[xfer] = cyc;
        if (psel && penable) begin
            if (wcnt == wait_states) begin
                pready  = 1'b1;
                pslverr = (xfer < 16) ? err_mask[xfer] : 1'b0;
                prdata  = 32'hA000_0000 | 32'(xfer);
                if (xfer < 16) begin
                    log_addr[xfer]  = paddr;
                    log_write[xfer] = pwrite;
                    log_wdata[xfer] = pwdata;
                    log_strb[xfer]  = pstrb;
                    log_en[xfer]    = wcnt + 1;
                end
                xfer++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = $urandom;
            end
            wcnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = $urandom;
            wcnt    = 0;
        end
    end

    // Per-beat records filled by do_read
    int          rb_n;
    logic [31:0] rb_data [16];
    logic [1:0]  rb_resp [16];
    logic        rb_last [16];
    bit          rb_stable[16];
    int          rb_hold [16];
    int          rb_hs   [16];
    logic [31:0] wb_data [4];
    logic [3:0]  wb_strb [4];

    function automatic logic [IW-1:0] mk(input logic id, input logic [31:0] a,
                                         input logic [7:0] len, input logic [1:0] b,
                                         input logic [2:0] s);
        return {id, a, len, b, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [IW-1:0] info, input int stall, output bit tmo);
        bit done = 0;
        int held = 0;
        tmo = 0;
        xfer = 0;
        rb_n = 0;
        rd_req_info = info;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (rd_req_ready) done = 1;
            tick();
        end
        rd_req_valid = 1'b0;
        if (!done) begin
            tmo = 1;
            return;
        end
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (rdata_valid && rb_n < 16) begin
                if (held == 0) begin
                    rb_data[rb_n]   = rdata;
                    rb_resp[rb_n]   = rdata_resp;
                    rb_last[rb_n]   = rdata_last;
                    rb_stable[rb_n] = 1;
                end else if (rdata !== rb_data[rb_n] || rdata_resp !== rb_resp[rb_n] ||
                             rdata_last !== rb_last[rb_n]) begin
                    rb_stable[rb_n] = 0;
                end
                held++;
                if (held > stall) begin
                    rdata_ready = 1'b1;
                    rb_hold[rb_n] = held;
                    rb_hs[rb_n] = cyc;
                    if (rdata_last) done = 1;
                    rb_n++;
                    held = 0;
                end
            end
            tick();
            rdata_ready = 1'b0;
        end
        tmo = !done;
    endtask

    task automatic do_write(input logic [IW-1:0] info, output logic [1:0] resp,
                            output logic id, output int nresp, output bit tmo);
        bit done = 0;
        int wi = 0;
        tmo = 0;
        nresp = 0;
        resp = 2'bxx;
        id = 1'bx;
        xfer = 0;
        wr_req_info = info;
        wr_req_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (wr_req_ready) done = 1;
            tick();
        end
        wr_req_valid = 1'b0;
        if (!done) begin
            tmo = 1;
            return;
        end
        done = 0;
        bresp_ready = 1'b1;
        wdata_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (wdata_ready && wi < 4) begin
                wdata = wb_data[wi];
                wstrb = wb_strb[wi];
                wi++;
            end
            if (bresp_valid) begin
                resp = bresp_resp;
                id = bresp_id;
                nresp = 1;
                done = 1;
            end
            tick();
        end
        wdata_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bresp_valid) nresp++;
            tick();
        end
        bresp_ready = 1'b0;
        tmo = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({psel, penable, pwrite, rdata_valid, bresp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 00000", {psel, penable, pwrite, rdata_valid, bresp_valid});
        end
        checks++;
        if ({paddr, pwdata, rdata} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h, want 0", paddr, pwdata, rdata);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({rd_req_ready, wr_req_ready, wdata_ready} !== 3'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 000", {rd_req_ready, wr_req_ready, wdata_ready});
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] order = '0;
        int ng = 0;
        bit both = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wait_states = 0;
        err_mask = '0;
        xfer = 0;
        rd_req_info = mk(1'b0, 32'h40, 8'd0, 2'b01, 3'd2);
        wr_req_info = mk(1'b1, 32'h80, 8'd0, 2'b01, 3'd2);
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        wdata_valid = 1'b1;
        rdata_ready = 1'b1;
        bresp_ready = 1'b1;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            #1;
            if (rd_req_ready && wr_req_ready) both = 1;
            if (rd_req_ready) begin
                order[ng] = 1'b0;
                ng++;
            end else if (wr_req_ready) begin
                order[ng] = 1'b1;
                ng++;
            end
            tick();
        end
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        repeat (12) tick();
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        bresp_ready = 1'b0;
        checks++;
        if (ng != 4 || order !== 4'b1010) begin
            errors++;
            $display("FAIL arb_order: grants=%0d order(lsb first, 1=W)=%b, want 4 grants 1010", ng, order);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL arb_exclusive: both readies seen together, want never");
        end
    endtask

    task automatic test_single_read();
        wait_states = 0;
        err_mask = '0;
        xfer = 0;
        rd_req_info = mk(1'b1, 32'h100, 8'd0, 2'b01, 3'd2);
        rd_req_valid = 1'b1;
        #1;
        checks++;
        if ({rd_req_ready, wr_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL sr_grant c0: ready rd/wr=%b, want 10", {rd_req_ready, wr_req_ready});
        end
        tick();
        rd_req_valid = 1'b0;
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== 32'h100) begin
            errors++;
            $display("FAIL sr_setup c1: sel/en/wr=%b paddr=%h, want 100 00000100", {psel, penable, pwrite}, paddr);
        end
        tick();
        checks++;
        if ({psel, penable, rdata_valid} !== 3'b110) begin
            errors++;
            $display("FAIL sr_access c2: sel/en/rv=%b, want 110", {psel, penable, rdata_valid});
        end
        tick();
        checks++;
        if ({psel, penable, rdata_valid} !== 3'b001) begin
            errors++;
            $display("FAIL sr_rvalid c3: sel/en/rv=%b, want 001", {psel, penable, rdata_valid});
        end
        checks++;
        if (rdata !== 32'hA000_0000 || rdata_last !== 1'b1 || rdata_resp !== 2'b00 || rdata_id !== 1'b1) begin
            errors++;
            $display("FAIL sr_beat: data=%h last=%b resp=%b id=%b, want a0000000 1 00 1",
                     rdata, rdata_last, rdata_resp, rdata_id);
        end
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        checks++;
        if (rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL sr_done: rdata_valid=%b, want 0", rdata_valid);
        end
    endtask

    task automatic test_incr_write();
        logic [1:0] resp;
        logic id;
        int nresp;
        bit tmo;
        logic [31:0] exp_addr[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        wb_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        wb_strb = '{4'hF, 4'h3, 4'hC, 4'h5};
        wait_states = 2;
        err_mask = '0;
        do_write(mk(1'b1, 32'h1000, 8'd3, 2'b01, 3'd2), resp, id, nresp, tmo);
        checks++;
        if (tmo || xfer != 4) begin
            errors++;
            $display("FAIL iw_count: timeout=%0d transfers=%0d, want 0 4", tmo, xfer);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (log_addr[b] !== exp_addr[b] || log_write[b] !== 1'b1 || log_wdata[b] !== wb_data[b] ||
                log_strb[b] !== wb_strb[b] || log_en[b] != 3) begin
                errors++;
                $display("FAIL iw_beat%0d: addr=%h wr=%b data=%h strb=%h en=%0d, want %h 1 %h %h 3",
                         b, log_addr[b], log_write[b], log_wdata[b], log_strb[b], log_en[b],
                         exp_addr[b], wb_data[b], wb_strb[b]);
            end
        end
        checks++;
        if (resp !== 2'b00 || id !== 1'b1 || nresp != 1) begin
            errors++;
            $display("FAIL iw_bresp: resp=%b id=%b count=%0d, want 00 1 1", resp, id, nresp);
        end
        wait_states = 0;
    endtask

    task automatic test_fixed_read();
        bit tmo;
        wait_states = 0;
        err_mask = '0;
        do_read(mk(1'b0, 32'h20, 8'd2, 2'b00, 3'd2), 4, tmo);
        checks++;
        if (tmo || rb_n != 3) begin
            errors++;
            $display("FAIL fr_count: timeout=%0d beats=%0d, want 0 3", tmo, rb_n);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (rb_data[b] !== (32'hA000_0000 | 32'(b)) || rb_last[b] !== (b == 2) || !rb_stable[b] ||
                rb_hold[b] != 5 || log_addr[b] !== 32'h20 || rb_resp[b] !== 2'b00) begin
                errors++;
                $display("FAIL fr_beat%0d: data=%h last=%b stable=%0d hold=%0d addr=%h resp=%b, want %h %0d 1 5 00000020 00",
                         b, rb_data[b], rb_last[b], rb_stable[b], rb_hold[b], log_addr[b], rb_resp[b],
                         32'hA000_0000 | 32'(b), (b == 2));
            end
        end
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (log_setup[b + 1] != rb_hs[b] + 1) begin
                errors++;
                $display("FAIL fr_next_psel%0d: setup at cycle %0d, want %0d", b, log_setup[b + 1], rb_hs[b] + 1);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        logic id;
        int nresp;
        bit tmo;
        wb_data = '{32'hDEAD_0000, 32'hDEAD_0001, 32'h0, 32'h0};
        wb_strb = '{4'hF, 4'hF, 4'h0, 4'h0};
        wait_states = 0;
        err_mask = 16'h0001;
        do_write(mk(1'b0, 32'h200, 8'd1, 2'b01, 3'd2), resp, id, nresp, tmo);
        checks++;
        if (tmo || resp !== 2'b10 || id !== 1'b0 || nresp != 1 || xfer != 2) begin
            errors++;
            $display("FAIL err_write: timeout=%0d resp=%b id=%b count=%0d transfers=%0d, want 0 10 0 1 2",
                     tmo, resp, id, nresp, xfer);
        end
        err_mask = 16'h0002;
        do_read(mk(1'b1, 32'h300, 8'd1, 2'b01, 3'd2), 0, tmo);
        checks++;
        if (tmo || rb_n != 2 || rb_resp[0] !== 2'b00 || rb_resp[1] !== 2'b10) begin
            errors++;
            $display("FAIL err_read: timeout=%0d beats=%0d resp0=%b resp1=%b, want 0 2 00 10",
                     tmo, rb_n, rb_resp[0], rb_resp[1]);
        end
        err_mask = '0;
    endtask

    task automatic test_wrap();
        bit tmo;
        wait_states = 1;
        do_read(mk(1'b0, 32'hFFFF_FFFC, 8'd1, 2'b01, 3'd2), 0, tmo);
        checks++;
        if (tmo || log_addr[0] !== 32'hFFFF_FFFC || log_addr[1] !== 32'h0 || rb_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_addr: timeout=%0d addr0=%h addr1=%h last1=%b, want 0 fffffffc 00000000 1",
                     tmo, log_addr[0], log_addr[1], rb_last[1]);
        end
        wait_states = 0;
    endtask

    task automatic test_reset_mid_burst();
        bit tmo;
        bit in_access = 0;
        wait_states = 50;
        xfer = 0;
        rd_req_info = mk(1'b0, 32'h500, 8'd3, 2'b01, 3'd2);
        rd_req_valid = 1'b1;
        for (int i = 0; i < 20 && !in_access; i++) begin
            tick();
            rd_req_valid = 1'b0;
            if (penable) in_access = 1;
        end
        checks++;
        if (!in_access) begin
            errors++;
            $display("FAIL rst_mid_access: penable never seen, want 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, rdata_valid, bresp_valid} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: sel/en/rv/bv=%b, want 0000", {psel, penable, rdata_valid, bresp_valid});
        end
        tick();
        tick();
        wait_states = 0;
        rst_n = 1'b1;
        tick();
        do_read(mk(1'b1, 32'h600, 8'd0, 2'b01, 3'd2), 0, tmo);
        checks++;
        if (tmo || rb_n != 1 || rb_data[0] !== 32'hA000_0000 || log_addr[0] !== 32'h600 || xfer != 1) begin
            errors++;
            $display("FAIL rst_recover: timeout=%0d beats=%0d data=%h addr=%h transfers=%0d, want 0 1 a0000000 00000600 1",
                     tmo, rb_n, rb_data[0], log_addr[0], xfer);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_read();
        test_incr_write();
        test_fixed_read();
        test_errors();
        test_wrap();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_txn_scheduler.md
Name: apb_txn_scheduler

Overview:
- Sequences the single APB master port of the AXI2APB bridge and shares it between the read path and the write path.
- Accepts whole-burst requests as packed addr_info_t from bridge_utils: {id, addr, len, burst, size}.
- Arbitrates round-robin between read and write, then expands each burst into len+1 APB transfers.
- Returns read beats, and one write response per burst, to the AXI-side channel logic.

Parameters:
ID_WIDTH, 1, transaction ID width
ADDR_WIDTH, 32, APB/AXI address width
DATA_WIDTH, 32, data width; DATA_WIDTH/8 strobe bits

Ports:
clk  in  1  clock
rst_n  in  1  reset
rd_req_valid  in  1  read burst request valid
rd_req_ready  out  1  read request accepted this cycle
rd_req_info  in  $bits(addr_info_t)  read burst descriptor
wr_req_valid  in  1  write burst request valid
wr_req_ready  out  1  write request accepted this cycle
wr_req_info  in  $bits(addr_info_t)  write burst descriptor
wdata_valid / wdata_ready  in / out  1  write beat handshake
wdata  in  DATA_WIDTH  write beat data
wstrb  in  DATA_WIDTH/8  write beat strobes
rdata_valid / rdata_ready  out / in  1  read beat handshake
rdata  out  DATA_WIDTH  read beat data
rdata_id  out  ID_WIDTH  read beat ID
rdata_resp  out  2  read beat response
rdata_last  out  1  last read beat
bresp_valid / bresp_ready  out / in  1  write response handshake
bresp_id  out  ID_WIDTH  write response ID
bresp_resp  out  2  write response
psel, penable, pwrite  out  1  APB control
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB write strobes
pready, pslverr  in  1  APB completion and error
prdata  in  DATA_WIDTH  APB read data

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All outputs are registered except rd_req_ready, wr_req_ready and wdata_ready, which are combinational from state.
  - Every output and internal register resets to 0; last_grant resets to WRITE.
- FSM states: IDLE, WDATA, SETUP, ACCESS, RD_OUT, B_OUT.
- IDLE:
  - Both valid: grant the type opposite to last_grant, so read wins first after reset. One valid: grant it.
  - Grant: the chosen *_req_ready is 1 for that cycle. Latch id, addr, beat counter = len, burst, size and type. Update last_grant. Clear the sticky error.
  - Next state: read to SETUP; write to WDATA.
- WDATA: wdata_ready=1. On handshake, latch wdata and wstrb into pwdata and pstrb, then go to SETUP.
- SETUP: psel=1, penable=0, paddr = current address, pwrite = type. Lasts exactly 1 cycle; pready is ignored. Then go to ACCESS.
- ACCESS: psel=1, penable=1, stable until pready=1. On pready, drop psel and penable in the next cycle, then:
  - Read: capture prdata into rdata. rdata_resp = pslverr ? 2'b10 : 2'b00. rdata_last = (counter==0). Go to RD_OUT.
  - Write: OR pslverr into the sticky error. Counter==0 goes to B_OUT; otherwise decrement the counter, advance the address, go to WDATA.
- RD_OUT: rdata_valid=1, data held stable until rdata_ready. Then last goes to IDLE; otherwise decrement the counter, advance the address, go to SETUP.
- B_OUT: bresp_valid=1, bresp_resp = sticky ? 2'b10 : 2'b00, held until bresp_ready. Then go to IDLE.
- Address advance:
  - burst 2'b00 (FIXED): address unchanged.
  - Any other burst code (INCR; WRAP is unsupported and treated as INCR): addr + (1<<size), modulo 2^ADDR_WIDTH.
  - size is not range-checked.
- Latency: read request accepted at cycle 0, psel at cycle 1, penable at cycle 2, rdata_valid at cycle 3 if pready=1 at cycle 2.
- One burst in flight at a time. Requests arriving while not in IDLE wait; ready stays 0.
- A burst with pslverr on every beat still completes all len+1 beats.
- Reset asserted mid-burst: immediate return to IDLE with all outputs 0. The in-flight burst is dropped, with no response.

Test Plan:
- Single read: rd addr=0x100, len=0, INCR, size=2; pready=1 in the first ACCESS cycle -> psel cycle 1, penable cycle 2, rdata_valid cycle 3 with rdata=prdata, rdata_last=1, resp=00.
- INCR write: len=3, size=2, addr=0x1000, 2 wait states per beat -> paddr 0x1000/1004/1008/100C, penable held 3 cycles each, pwdata/pstrb match beats in order, one bresp=00.
- FIXED read: len=2, addr=0x20 -> three transfers all at 0x20, rdata_last only on the third; stalling rdata_ready 4 cycles holds rdata stable and delays the next psel.
- Arbitration: rd and wr valid together from reset -> read granted first, write next; repeated simultaneous requests alternate R,W,R,W.
- Error: write len=1, pslverr on beat 0 only -> bresp=10; read len=1, pslverr on beat 1 -> rdata_resp 00 then 10.
- Wrap and reset: INCR at addr=0xFFFFFFFC, len=1 -> second paddr=0x00000000. Assert rst_n low during ACCESS -> psel, penable and all valids go to 0 immediately; after release the next request is served normally.
